// File: rtl/dff_pipeline_pkg.sv
// rtl/dff_pipeline_pkg.sv - shared constants and parameter checks for the elastic register pipeline
package dff_pipeline_pkg;

  // Width of the occupancy counter: must represent 0..stages inclusive.
  function automatic int count_width(input int stages);
    return $clog2(stages + 1);
  endfunction

  // Legal parameter combinations: at least one data bit and at least one stage.
  function automatic bit params_legal(input int width, input int stages);
    return (width >= 1) && (stages >= 1);
  endfunction

endpackage

// File: rtl/dff_pipe_stage.sv
// rtl/dff_pipe_stage.sv - one pipeline stage: valid bit plus data register with load enable and flush
module dff_pipe_stage
  import dff_pipeline_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             load,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  // Flush only drops the valid bit; data is kept so a stalled output never glitches.
  // An empty upstream slot loaded in leaves the stale data untouched.
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= up_valid;
      if (up_valid) begin
        data <= up_data;
      end
    end
  end

endmodule

// File: rtl/dff_pipeline.sv
// rtl/dff_pipeline.sv - elastic multi-stage register pipeline with valid/ready, stall, flush and occupancy
module dff_pipeline
  import dff_pipeline_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 4
) (
  input  logic                             Clk,
  input  logic                             reset,
  input  logic                             enable,
  input  logic                             flush,
  input  logic                             in_valid,
  input  logic [WIDTH-1:0]                 in_data,
  output logic                             in_ready,
  output logic                             out_valid,
  output logic [WIDTH-1:0]                 out_data,
  input  logic                             out_ready,
  output logic [count_width(STAGES)-1:0]   count
);

  localparam int CW = count_width(STAGES);

  if (!params_legal(WIDTH, STAGES)) begin : g_illegal_params
    $error("dff_pipeline: WIDTH and STAGES must both be >= 1");
  end

  logic [STAGES-1:0] v;
  logic [STAGES-1:0] rdy;
  logic [WIDTH-1:0]  d [STAGES];

  // Ready chain, walked from the output back: a stage can load if any stage
  // at or after it is empty, or the output is draining. This is what lets
  // bubbles collapse while later stages are stalled.
  always_comb begin
    logic chain;
    rdy   = '0;
    chain = out_ready;
    for (int i = STAGES - 1; i >= 0; i--) begin
      chain  = !v[i] || chain;
      rdy[i] = chain;
    end
  end

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    logic             stage_up_valid;
    logic [WIDTH-1:0] stage_up_data;

    if (i == 0) begin : g_head
      assign stage_up_valid = in_valid;
      assign stage_up_data  = in_data;
    end else begin : g_body
      assign stage_up_valid = v[i-1];
      assign stage_up_data  = d[i-1];
    end

    dff_pipe_stage #(
      .WIDTH (WIDTH)
    ) u_stage (
      .Clk      (Clk),
      .reset    (reset),
      .flush    (flush),
      .load     (enable && rdy[i]),
      .up_valid (stage_up_valid),
      .up_data  (stage_up_data),
      .valid    (v[i]),
      .data     (d[i])
    );
  end

  // Both handshakes are masked while stalled, flushing or held in reset so no
  // transfer can be observed in a cycle that does not move state.
  assign in_ready  = !reset && enable && !flush && rdy[0];
  assign out_valid = !reset && enable && !flush && v[STAGES-1];
  assign out_data  = d[STAGES-1];

  // Occupancy is a popcount of the registered valid bits only.
  always_comb begin
    count = '0;
    for (int i = 0; i < STAGES; i++) begin
      count = count + CW'(v[i]);
    end
  end

endmodule

// File: tb/tb_dff_pipeline.sv
// tb/tb_dff_pipeline.sv - self-checking bench for dff_pipeline
module tb_dff_pipeline;

  localparam int W  = 8;
  localparam int S  = 4;
  localparam int CW = $clog2(S + 1);

  logic          Clk = 1'b0;
  logic          reset;
  logic          enable;
  logic          flush;
  logic          in_valid;
  logic [W-1:0]  in_data;
  logic          in_ready;
  logic          out_valid;
  logic [W-1:0]  out_data;
  logic          out_ready;
  logic [CW-1:0] count;

  int checks   = 0;
  int failures = 0;

  always #5 Clk = ~Clk;

  dff_pipeline #(
    .WIDTH  (W),
    .STAGES (S)
  ) dut (
    .Clk       (Clk),
    .reset     (reset),
    .enable    (enable),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .count     (count)
  );

  typedef struct {
    logic         en;
    logic         fl;
    logic         iv;
    logic [W-1:0] id;
    logic         ordy;
    logic         exp_ir;
    logic         exp_ov;
    logic         chk_d;
    logic [W-1:0] exp_d;
    int           exp_cnt;
  } vec_t;

  vec_t tbl [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic en, input logic fl, input logic iv,
                       input logic [W-1:0] id, input logic ordy);
    @(negedge Clk);
    enable    = en;
    flush     = fl;
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    enable    = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    @(negedge Clk);
    #1;
    chk("reset_in_ready", 32'(in_ready), 0);
    chk("reset_out_valid", 32'(out_valid), 0);
    chk("reset_out_data", 32'(out_data), 0);
    chk("reset_count", 32'(count), 0);
    @(negedge Clk);
    reset = 1'b0;
  endtask

  bit           mv [S];
  logic [W-1:0] md [S];

  initial begin
    int nemit;
    int cnt;
    logic en, fl, iv, ordy, e_ir, e_ov;
    logic [W-1:0] id;

    //          en fl iv  id     ordy ir ov chkd  d      cnt
    tbl[0]  = '{1, 0, 1, 8'h01, 0,   1, 0, 0, 8'h00, 0};
    tbl[1]  = '{1, 0, 1, 8'h02, 0,   1, 0, 0, 8'h00, 1};
    tbl[2]  = '{1, 0, 1, 8'h03, 0,   1, 0, 0, 8'h00, 2};
    tbl[3]  = '{1, 0, 1, 8'h04, 0,   1, 0, 0, 8'h00, 3};
    tbl[4]  = '{1, 0, 1, 8'h05, 0,   0, 1, 1, 8'h01, 4};
    tbl[5]  = '{1, 0, 1, 8'h05, 1,   1, 1, 1, 8'h01, 4};
    tbl[6]  = '{1, 0, 0, 8'h00, 0,   0, 1, 1, 8'h02, 4};
    tbl[7]  = '{1, 0, 0, 8'h00, 1,   1, 1, 1, 8'h02, 4};
    tbl[8]  = '{1, 0, 0, 8'h00, 0,   1, 1, 1, 8'h03, 3};
    tbl[9]  = '{0, 0, 1, 8'h99, 1,   0, 0, 1, 8'h03, 3};
    tbl[10] = '{1, 1, 1, 8'hAA, 1,   0, 0, 1, 8'h03, 3};
    tbl[11] = '{1, 0, 0, 8'h00, 1,   1, 0, 0, 8'h00, 0};
    tbl[12] = '{1, 0, 0, 8'h00, 1,   1, 0, 0, 8'h00, 0};

    // Table: fill under backpressure, full accept+emit, stall, flush.
    do_reset();
    for (int k = 0; k < 13; k++) begin
      drive(tbl[k].en, tbl[k].fl, tbl[k].iv, tbl[k].id, tbl[k].ordy);
      chk($sformatf("tbl%0d_in_ready", k), 32'(in_ready), 32'(tbl[k].exp_ir));
      chk($sformatf("tbl%0d_out_valid", k), 32'(out_valid), 32'(tbl[k].exp_ov));
      chk($sformatf("tbl%0d_count", k), 32'(count), 32'(tbl[k].exp_cnt));
      if (tbl[k].chk_d) chk($sformatf("tbl%0d_out_data", k), 32'(out_data), 32'(tbl[k].exp_d));
    end

    // Stream 0x01..0x08 with no backpressure: latency 4, one item per cycle.
    do_reset();
    nemit = 0;
    for (int k = 0; k < 16; k++) begin
      drive(1'b1, 1'b0, k < 8, W'(k + 1), 1'b1);
      if (k < 8) chk("stream_in_ready", 32'(in_ready), 1);
      if (k == 6) chk("stream_count", 32'(count), 4);
      if (out_valid) begin
        chk("stream_data", 32'(out_data), 32'(nemit + 1));
        chk("stream_latency", 32'(k), 32'(nemit + 4));
        nemit++;
      end
    end
    chk("stream_items", 32'(nemit), 8);

    // Single item collapses to the last stage and holds; second stops at stage 2.
    do_reset();
    drive(1'b1, 1'b0, 1'b1, 8'hA5, 1'b0);
    chk("collapse_accept", 32'(in_ready), 1);
    for (int k = 1; k < 4; k++) begin
      drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
      chk("collapse_early_valid", 32'(out_valid), 0);
    end
    drive(1'b1, 1'b0, 1'b1, 8'h5A, 1'b0);
    chk("collapse_arrive_valid", 32'(out_valid), 1);
    chk("collapse_arrive_data", 32'(out_data), 32'h A5);
    chk("collapse_second_accept", 32'(in_ready), 1);
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
      chk("collapse_hold_data", 32'(out_data), 32'h A5);
      chk("collapse_hold_valid", 32'(out_valid), 1);
    end
    chk("collapse_count", 32'(count), 2);
    drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    chk("collapse_emit1", 32'(out_data), 32'h A5);
    drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    chk("collapse_emit2_valid", 32'(out_valid), 1);
    chk("collapse_emit2", 32'(out_data), 32'h 5A);
    drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    chk("collapse_empty", 32'(count), 0);

    // Asynchronous reset between edges with two items held.
    do_reset();
    drive(1'b1, 1'b0, 1'b1, 8'h11, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 8'h22, 1'b0);
    for (int k = 0; k < 3; k++) drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("areset_pre_count", 32'(count), 2);
    chk("areset_pre_data", 32'(out_data), 32'h 11);
    #1;
    reset = 1'b1;
    #1;
    chk("areset_out_valid", 32'(out_valid), 0);
    chk("areset_out_data", 32'(out_data), 0);
    chk("areset_count", 32'(count), 0);
    chk("areset_in_ready", 32'(in_ready), 0);
    @(negedge Clk);
    reset = 1'b0;
    drive(1'b1, 1'b0, 1'b1, 8'h33, 1'b1);
    chk("areset_33_accept", 32'(in_ready), 1);
    for (int k = 1; k < 4; k++) begin
      drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
      chk("areset_33_early", 32'(out_valid), 0);
    end
    drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    chk("areset_33_valid", 32'(out_valid), 1);
    chk("areset_33_data", 32'(out_data), 32'h 33);

    // Random traffic against a slot-compaction model of the pipeline.
    do_reset();
    for (int i = 0; i < S; i++) begin
      mv[i] = 1'b0;
      md[i] = '0;
    end
    for (int k = 0; k < 600; k++) begin
      en   = ($urandom_range(0, 9) != 0);
      fl   = ($urandom_range(0, 24) == 0);
      iv   = ($urandom_range(0, 2) != 0);
      id   = W'($urandom);
      ordy = ($urandom_range(0, 3) != 0);
      drive(en, fl, iv, id, ordy);

      cnt = 0;
      for (int i = 0; i < S; i++) cnt += int'(mv[i]);
      e_ir = en && !fl && (cnt < S || ordy);
      e_ov = en && !fl && mv[S-1];
      chk("rand_in_ready", 32'(in_ready), 32'(e_ir));
      chk("rand_out_valid", 32'(out_valid), 32'(e_ov));
      chk("rand_count", 32'(count), 32'(cnt));
      if (e_ov) chk("rand_out_data", 32'(out_data), 32'(md[S-1]));

      if (fl) begin
        for (int i = 0; i < S; i++) mv[i] = 1'b0;
      end else if (en) begin
        if (mv[S-1] && ordy) mv[S-1] = 1'b0;
        for (int i = S - 2; i >= 0; i--) begin
          if (mv[i] && !mv[i+1]) begin
            mv[i+1] = 1'b1;
            md[i+1] = md[i];
            mv[i]   = 1'b0;
          end
        end
        if (e_ir && iv) begin
          mv[0] = 1'b1;
          md[0] = id;
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dff_pipeline.md
# dff_pipeline

Parametrised elastic register pipeline: STAGES cascaded WIDTH-bit enable/reset flip-flop stages with per-stage valid bits, valid/ready handshakes at both ends, global enable (stall), synchronous flush and occupancy count. It is the multi-bit, multi-stage successor of the single enabled D flip-flop. It sits on any datapath that needs fixed-latency registering with downstream backpressure.

## Interface
- WIDTH, 8, data bits per stage (>= 1)
- STAGES, 4, number of register stages (>= 1; 1 is legal)
- Clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clears all stage valids and data
- enable  in  1  global advance enable; 0 freezes all state and masks both handshakes
- flush  in  1  synchronous clear of all stage valid bits; priority over everything except reset
- in_valid  in  1  upstream item present
- in_data  in  WIDTH  upstream data
- in_ready  out  1  pipeline accepts in_data this cycle
- out_valid  out  1  last stage holds an item
- out_data  out  WIDTH  last-stage data
- out_ready  in  1  downstream accepts this cycle
- count  out  $clog2(STAGES+1)  number of valid stages, 0..STAGES

## Operation
- Stage i holds v[i] and d[i]; stage 0 is fed from in_*, stage STAGES-1 drives out_*.
- Downstream ready for stage i: r[i] = out_ready for i = STAGES-1, else rdy[i+1]. Stage ready: rdy[i] = !v[i] || r[i].
- Stage i loads at an edge when enable && !flush && rdy[i]: v[i] <= upstream valid, d[i] <= upstream data when upstream valid (otherwise d[i] unchanged).
- in_ready = enable && !flush && rdy[0]. out_valid = enable && !flush && v[STAGES-1]. out_data = d[STAGES-1] always (unmasked).
- Input transfer: in_valid && in_ready. Output transfer: out_valid && out_ready.
- Bubble collapse: an empty stage fills even while stages after it are stalled.
- enable = 0: no v/d change; in_ready = 0, out_valid = 0; count still reports state.
- flush = 1 (enable either value): all v[i] <= 0 at the edge; d[] unchanged; no transfer in that cycle (in_ready = out_valid = 0).
- count = popcount(v[]) of registered state; combinational from the registers only, never from inputs.
- Reset asserted at any time, including mid-transfer: all v[i] and d[i] go to 0 immediately; items in flight are lost.

## Timing
- Reset values: in_ready = 0 while reset high (follows enable/flush after release), out_valid = 0, out_data = 0, count = 0.
- Latency: item accepted in cycle c appears with out_valid = 1 in cycle c+STAGES when no stalls occur.
- Throughput: one item per cycle sustained when out_ready = 1 and enable = 1.
- Full (count = STAGES): in_ready = out_ready (combinational path out_ready -> in_ready through every stage); simultaneous accept and emit is allowed.
- Empty (count = 0): in_ready = enable && !flush; out_valid = 0.
- While out_valid && !out_ready, out_data holds stable until the transfer.
- Order preserved; no item is duplicated or dropped except by flush or reset.

## Structure
- Shared package dff_pipeline_pkg: count-width constant function (clog2 of STAGES+1) and parameter legality checks (WIDTH >= 1, STAGES >= 1).
- One sub-module, dff_pipe_stage: one valid bit plus a WIDTH-bit register with load enable, async active-high reset and sync flush. It is instantiated STAGES times in a generate loop. The top contains only the ready chain, masking and count.

## Test plan
- Reset then stream 0x01..0x08 with out_ready = 1, enable = 1 -> first out_valid 4 cycles after 0x01 is accepted, one item per cycle, order 0x01..0x08, count steady at 4.
- Fill with out_ready = 0 -> after 4 accepts count = 4 and in_ready = 0. Raise out_ready -> in_ready = 1 in the same cycle, 0x01 emitted, new item accepted simultaneously.
- Single item 0xA5 with out_ready = 0 -> 0xA5 collapses to the last stage in 4 cycles and out_data stays 0xA5 until out_ready = 1. A second item 0x5A collapses to stage 2.
- enable = 0 for 3 cycles mid-stream -> in_ready = 0, out_valid = 0, count frozen. Resume -> stream continues with no loss or duplication.
- flush with count = 3 and in_valid = 1 -> next cycle count = 0, flushed items never appear, the in_data presented during flush is not accepted.
- Assert reset asynchronously between edges with count = 2 -> out_valid, out_data, count = 0 immediately. After release, 0x33 passes with 4-cycle latency.
